// File: rtl/ysyx_24100005_fetch_ctrl.sv
// Multi-cycle fetch/execute sequencer for the NPC core.
// Fetches one instruction at a time over a valid/ready memory interface,
// latches it for decode and pulses exec_valid for one cycle to commit it.
// Stops for good on ebreak (halted) or on a memory error/timeout (fault).
module ysyx_24100005_fetch_ctrl #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_W     = 8,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic [31:0] pc_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    output logic        imem_rsp_ready_o,
    output logic [31:0] inst_o,
    output logic        exec_valid_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] inst_cnt_o
);

    localparam logic [31:0]     EBREAK      = 32'h0010_0073;
    localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_e;

    state_e          state_q;
    logic            req_valid_q;
    logic [31:0]     req_addr_q;
    logic            rsp_ready_q;
    logic [31:0]     inst_q;
    logic            exec_valid_q;
    logic            halted_q;
    logic            fault_q;
    logic [31:0]     inst_cnt_q;
    logic [TO_W-1:0] to_cnt_q;

    logic [TO_W-1:0] to_cnt_d;
    logic            timeout_hit;

    // Next value of the REQ+WAIT cycle counter and whether this cycle is the last allowed one.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a missing default infers a latch.
        to_cnt_d    = to_cnt_q + TO_W'(1);
        timeout_hit = (to_cnt_d == TIMEOUT_CNT);
    end

    // Sequencer state and all of its registered (Moore) outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_valid_q  <= 1'b0;
            req_addr_q   <= 32'h0;
            rsp_ready_q  <= 1'b0;
            inst_q       <= NOP_INST;
            exec_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            inst_cnt_q   <= 32'h0;
            to_cnt_q     <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
            exec_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= pc_i;
                        to_cnt_q    <= '0;
                    end
                end
                S_REQ: begin
                    // Handshake beats the timeout; the counter saturates so WAIT can still time out.
                    if (imem_req_ready_i) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        if (!timeout_hit) to_cnt_q <= to_cnt_d;
                    end else if (timeout_hit) begin
                        state_q     <= S_FAULT;
                        req_valid_q <= 1'b0;
                        fault_q     <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        rsp_ready_q <= 1'b0;
                        if (imem_rsp_err_i) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q      <= S_EXEC;
                            inst_q       <= imem_rsp_data_i;
                            exec_valid_q <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_q     <= S_FAULT;
                        rsp_ready_q <= 1'b0;
                        fault_q     <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
                S_EXEC: begin
                    inst_cnt_q <= inst_cnt_q + 32'd1;
                    if (inst_q == EBREAK) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (run_i) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= pc_i;
                        to_cnt_q    <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALT, S_FAULT: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = req_addr_q;
    assign imem_rsp_ready_o = rsp_ready_q;
    assign inst_o           = inst_q;
    assign exec_valid_o     = exec_valid_q;
    assign halted_o         = halted_q;
    assign fault_o          = fault_q;
    assign inst_cnt_o       = inst_cnt_q;

endmodule

// File: tb/tb_ysyx_24100005_fetch_ctrl.sv
// Directed bench for ysyx_24100005_fetch_ctrl: a default instance for the
// fetch/execute flows and a TIMEOUT=4 instance for the timeout corner cases.
module tb_ysyx_24100005_fetch_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [31:0] pc;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;
    logic [31:0] inst;
    logic        exec_valid;
    logic        halted;
    logic        fault;
    logic [31:0] inst_cnt;

    logic        run_to;
    logic        req_valid_to;
    logic [31:0] req_addr_to;
    logic        req_ready_to;
    logic        rsp_valid_to;
    logic        rsp_ready_to;
    logic [31:0] inst_to;
    logic        exec_valid_to;
    logic        halted_to;
    logic        fault_to;
    logic [31:0] inst_cnt_to;

    logic        auto_mem;
    logic [31:0] rom [4];

    int n_vec;
    int n_err;

    ysyx_24100005_fetch_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .run_i            (run),
        .pc_i             (pc),
        .imem_req_valid_o (req_valid),
        .imem_req_addr_o  (req_addr),
        .imem_req_ready_i (req_ready),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .imem_rsp_err_i   (rsp_err),
        .imem_rsp_ready_o (rsp_ready),
        .inst_o           (inst),
        .exec_valid_o     (exec_valid),
        .halted_o         (halted),
        .fault_o          (fault),
        .inst_cnt_o       (inst_cnt)
    );

    ysyx_24100005_fetch_ctrl #(.TIMEOUT(4)) dut_to (
        .clk              (clk),
        .rst_n            (rst_n),
        .run_i            (run_to),
        .pc_i             (pc),
        .imem_req_valid_o (req_valid_to),
        .imem_req_addr_o  (req_addr_to),
        .imem_req_ready_i (req_ready_to),
        .imem_rsp_valid_i (rsp_valid_to),
        .imem_rsp_data_i  (rsp_data),
        .imem_rsp_err_i   (rsp_err),
        .imem_rsp_ready_o (rsp_ready_to),
        .inst_o           (inst_to),
        .exec_valid_o     (exec_valid_to),
        .halted_o         (halted_to),
        .fault_o          (fault_to),
        .inst_cnt_o       (inst_cnt_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; in auto mode act as a zero-wait ROM
    // and as a PC register that steps by 4 on each committed instruction.
    task automatic step();
        @(negedge clk);
        if (auto_mem) begin
            if (exec_valid) pc = pc + 32'd4;
            rsp_data = rom[req_addr[3:2]];
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rom[0] = 32'h0010_0093;
        rom[1] = 32'h0020_8113;
        rom[2] = 32'h0031_0193;
        rom[3] = 32'h0041_8213;
        rst_n = 1'b0; run = 1'b0; pc = 32'h0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;
        run_to = 1'b0; req_ready_to = 1'b0; rsp_valid_to = 1'b0;
        auto_mem = 1'b0;

        // Reset values
        step();
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_rsp_ready", rsp_ready, 1'b0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_exec", exec_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_inst_cnt", inst_cnt, 32'h0);

        // Zero-wait memory, four addi, exec_valid every third cycle
        rst_n = 1'b1;
        pc = 32'h8000_0000; req_ready = 1'b1; rsp_valid = 1'b1; auto_mem = 1'b1; run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t1_exec_c%0d", k), exec_valid, (k % 3) == 0);
            if (k % 3 == 1) begin
                check($sformatf("t1_addr_c%0d", k), req_addr, 32'h8000_0000 + 32'(4 * ((k - 1) / 3)));
                check($sformatf("t1_reqv_c%0d", k), req_valid, 1'b1);
            end
            if (k == 3) check("t1_inst0", inst, rom[0]);
            if (k == 12) check("t1_cnt_c12", inst_cnt, 32'd3);
            if (k == 10) run = 1'b0;
        end
        step();
        check("t1_idle_reqv", req_valid, 1'b0);
        check("t1_inst_cnt", inst_cnt, 32'd4);
        check("t1_inst_last", inst, rom[3]);
        auto_mem = 1'b0;

        // Stalled request and late response; stray responses outside WAIT ignored
        pc = 32'h8000_0100; req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0113; run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t2_reqv_c%0d", k), req_valid, 1'b1);
            check($sformatf("t2_addr_c%0d", k), req_addr, 32'h8000_0100);
            check($sformatf("t2_inst_c%0d", k), inst, rom[3]);
            if (k == 2) pc = 32'hDEAD_BEEF;
            if (k == 5) begin
                req_ready = 1'b1;
                rsp_valid = 1'b0;
            end
        end
        step();
        check("t2_wait_reqv", req_valid, 1'b0);
        check("t2_wait_rspr", rsp_ready, 1'b1);
        req_ready = 1'b0; rsp_data = 32'h0051_0293;
        step();
        run = 1'b0;
        step();
        check("t2_no_exec", exec_valid, 1'b0);
        rsp_valid = 1'b1;
        step();
        check("t2_exec", exec_valid, 1'b1);
        check("t2_inst", inst, 32'h0051_0293);
        rsp_valid = 1'b0;
        step();
        check("t2_exec_off", exec_valid, 1'b0);
        check("t2_cnt", inst_cnt, 32'd5);
        check("t2_inst_hold", inst, 32'h0051_0293);
        step();
        check("t2_parked", req_valid, 1'b0);

        // ebreak retires once, then HALT is absorbing
        pc = 32'h8000_0200; req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = EBREAK; run = 1'b1;
        step();
        check("t3_addr", req_addr, 32'h8000_0200);
        step();
        step();
        check("t3_exec", exec_valid, 1'b1);
        step();
        check("t3_halted", halted, 1'b1);
        check("t3_cnt", inst_cnt, 32'd6);
        check("t3_exec_off", exec_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t3_hold_reqv%0d", k), req_valid, 1'b0);
            check($sformatf("t3_hold_exec%0d", k), exec_valid, 1'b0);
            check($sformatf("t3_hold_halt%0d", k), halted, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t3_rst_halted", halted, 1'b0);
        check("t3_rst_cnt", inst_cnt, 32'h0);
        check("t3_rst_inst", inst, NOP);
        run = 1'b0;
        step();
        rst_n = 1'b1;

        // Response error -> FAULT, no exec_valid
        pc = 32'h8000_0300; req_ready = 1'b1; rsp_valid = 1'b1; rsp_err = 1'b1; run = 1'b1;
        step();
        step();
        check("t4_pre_fault", fault, 1'b0);
        step();
        check("t4_fault", fault, 1'b1);
        check("t4_no_exec", exec_valid, 1'b0);
        check("t4_rspr", rsp_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t4_hold_exec%0d", k), exec_valid, 1'b0);
            check($sformatf("t4_hold_reqv%0d", k), req_valid, 1'b0);
            check($sformatf("t4_hold_fault%0d", k), fault, 1'b1);
        end
        check("t4_inst", inst, NOP);
        rst_n = 1'b0; run = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        step();
        rst_n = 1'b1;

        // TIMEOUT=4 with ready never high -> FAULT after 4 REQ cycles
        run_to = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t5_reqv_c%0d", k), req_valid_to, 1'b1);
            check($sformatf("t5_nofault_c%0d", k), fault_to, 1'b0);
        end
        step();
        check("t5_fault", fault_to, 1'b1);
        check("t5_reqv_off", req_valid_to, 1'b0);
        rst_n = 1'b0; run_to = 1'b0;
        step();
        rst_n = 1'b1;

        // Completion in the timeout cycle wins, in REQ and then in WAIT
        run_to = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t6_reqv_c%0d", k), req_valid_to, 1'b1);
        end
        req_ready_to = 1'b1;
        step();
        check("t6_win_req", fault_to, 1'b0);
        check("t6_wait", rsp_ready_to, 1'b1);
        req_ready_to = 1'b0; rsp_valid_to = 1'b1; rsp_data = 32'h0070_0393;
        step();
        check("t6_win_wait", fault_to, 1'b0);
        check("t6_exec", exec_valid_to, 1'b1);
        check("t6_inst", inst_to, 32'h0070_0393);
        run_to = 1'b0; rsp_valid_to = 1'b0;

        // Async reset mid-WAIT drops the in-flight response
        pc = 32'h8000_0400; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h1234_5678; run = 1'b1;
        step();
        check("t7_addr", req_addr, 32'h8000_0400);
        step();
        check("t7_wait", rsp_ready, 1'b1);
        #2 rst_n = 1'b0; rsp_valid = 1'b1;
        #1;
        check("t7_rst_addr", req_addr, 32'h0);
        check("t7_rst_rspr", rsp_ready, 1'b0);
        check("t7_rst_reqv", req_valid, 1'b0);
        check("t7_rst_exec", exec_valid, 1'b0);
        check("t7_rst_inst", inst, NOP);
        step();
        check("t7_dropped", inst, NOP);
        rst_n = 1'b1; run = 1'b0; rsp_valid = 1'b0;
        step();
        check("t7_idle_reqv", req_valid, 1'b0);
        check("t7_idle_inst", inst, NOP);
        check("t7_idle_cnt", inst_cnt, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
